// File: rtl/mem_pkg.sv
// ============================================================================
// Module      : mem_pkg
// Description : Size encodings, FSM states and address-width default shared
//               by the load/store unit and its lane-alignment helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_pkg;

  localparam int MEM_ADDR_W_DEF = 16;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MERGE = 3'd2,
    WRITE = 3'd3,
    RESP  = 3'd4
  } lsu_state_e;

  // The reserved size code is always reported as misaligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = off[0];
      SZ_WORD: mis = (off != 2'b00);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_lane_align.sv
// ============================================================================
// Module      : lsu_lane_align
// Description : Combinational lane handling: load extract/extend and
//               sub-word store merge into an existing memory word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merge_data_o
);

  logic [4:0]  w_shamt;
  logic [31:0] w_shifted;
  logic [31:0] w_mask;
  logic [31:0] w_ins;

  assign w_shamt   = {offset_i, 3'b000};
  assign w_shifted = rdata_i >> w_shamt;

  always_comb begin
    load_data_o = rdata_i;
    case (size_i)
      SZ_BYTE: load_data_o = {{24{~unsigned_i & w_shifted[7]}}, w_shifted[7:0]};
      SZ_HALF: load_data_o = {{16{~unsigned_i & w_shifted[15]}}, w_shifted[15:0]};
      default: load_data_o = rdata_i;
    endcase
  end

  // Halfword lanes are placed by offset[1] only; offset[0] is a misalignment.
  always_comb begin
    w_mask       = 32'h0000_0000;
    w_ins        = 32'h0000_0000;
    merge_data_o = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        w_mask       = 32'h0000_00FF << w_shamt;
        w_ins        = {24'h0, wdata_i[7:0]} << w_shamt;
        merge_data_o = (rdata_i & ~w_mask) | w_ins;
      end
      SZ_HALF: begin
        w_mask       = 32'h0000_FFFF << {offset_i[1], 4'b0000};
        w_ins        = {16'h0, wdata_i[15:0]} << {offset_i[1], 4'b0000};
        merge_data_o = (rdata_i & ~w_mask) | w_ins;
      end
      default: merge_data_o = wdata_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module      : load_store_unit
// Description : MEM-stage access controller for a word-wide DataMemory;
//               sub-word stores are done as read-modify-write.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit
  import mem_pkg::*;
#(
  parameter int MEM_ADDR_W = MEM_ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic                  mem_write_en,
  output logic [31:0]           mem_write_data,
  input  logic [31:0]           mem_read_data
);

  lsu_state_e            state_q, state_d;
  logic [MEM_ADDR_W-1:0] idx_q;
  logic [1:0]            off_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic                  err_q;
  logic [31:0]           wdata_q;
  logic [31:0]           rdata_q;

  logic                  w_accept;
  logic                  w_mis;
  logic [31:0]           w_load_data;
  logic [31:0]           w_merge_data;
  logic                  unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:MEM_ADDR_W+2];

  assign w_accept = req_valid & req_ready;
  assign w_mis    = is_misaligned(req_size, req_addr[1:0]);

  lsu_lane_align u_align (
    .rdata_i      (mem_read_data),
    .wdata_i      (wdata_q),
    .offset_i     (off_q),
    .size_i       (size_q),
    .unsigned_i   (uns_q),
    .load_data_o  (w_load_data),
    .merge_data_o (w_merge_data)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (w_mis)                  state_d = RESP;
          else if (!req_write)        state_d = LOAD;
          else if (req_size == SZ_WORD) state_d = WRITE;
          else                        state_d = MERGE;
        end
      end
      LOAD:    state_d = RESP;
      MERGE:   state_d = WRITE;
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      off_q   <= 2'b00;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (w_accept) begin
        idx_q   <= req_addr[MEM_ADDR_W+1:2];
        off_q   <= req_addr[1:0];
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        err_q   <= w_mis;
        wdata_q <= req_wdata;
        if (req_write) rdata_q <= 32'h0;
      end
      if (state_q == LOAD)  rdata_q <= w_load_data;
      // The merged word replaces the store data so WRITE has one source.
      if (state_q == MERGE) wdata_q <= w_merge_data;
    end
  end

  assign req_ready      = (state_q == IDLE);
  assign resp_valid     = (state_q == RESP);
  assign resp_err       = (state_q == RESP) & err_q;
  assign resp_rdata     = rdata_q;
  assign mem_addr       = idx_q;
  assign mem_write_en   = (state_q == WRITE) & ~reset;
  assign mem_write_data = (state_q == WRITE) ? wdata_q : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module      : tb_load_store_unit
// Description : Directed self-checking bench for load_store_unit with a
//               small combinational-read DataMemory model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [15:0] mem_addr;
  logic        mem_write_en;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  logic [31:0] mem [0:63];
  int checks = 0;
  int errors = 0;

  load_store_unit #(.MEM_ADDR_W(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_size       (req_size),
    .req_unsigned   (req_unsigned),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_addr       (mem_addr),
    .mem_write_en   (mem_write_en),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_addr[5:0]];
  always @(posedge clk) if (mem_write_en) mem[mem_addr[5:0]] <= mem_write_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request from a post-edge point; returns one cycle after resp_valid.
  task automatic do_req(input string tag, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                        input int lat, input logic chk_rd, input logic [31:0] exp_rd,
                        input logic exp_err, input int exp_we);
    int n;
    int we_cnt;
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk({tag, ".ready_busy"}, {31'h0, req_ready}, 32'h0);
    n = 1;
    we_cnt = 0;
    while (!resp_valid && n < 8) begin
      if (mem_write_en) we_cnt++;
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ".latency"}, n, lat);
    chk({tag, ".err"}, {31'h0, resp_err}, {31'h0, exp_err});
    if (chk_rd) chk({tag, ".rdata"}, resp_rdata, exp_rd);
    chk({tag, ".we_cycles"}, we_cnt, exp_we);
    @(posedge clk); #1;
    chk({tag, ".resp_drop"}, {31'h0, resp_valid}, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst.ready", {31'h0, req_ready}, 32'h1);
    chk("rst.resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst.rdata", resp_rdata, 32'h0);
    chk("rst.err", {31'h0, resp_err}, 32'h0);
    chk("rst.we", {31'h0, mem_write_en}, 32'h0);
    chk("rst.addr", {16'h0, mem_addr}, 32'h0);
    chk("rst.wdata", mem_write_data, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Word store then word load
    do_req("sw1", 1, 2'd2, 0, 32'h0C, 32'h0000_03FF, 2, 1, 32'h0, 0, 1);
    chk("sw1.mem3", mem[3], 32'h0000_03FF);
    do_req("lw1", 0, 2'd2, 0, 32'h0C, 32'h0, 2, 1, 32'h0000_03FF, 0, 0);

    // Byte store by read-modify-write
    do_req("sw2", 1, 2'd2, 0, 32'h0C, 32'h1122_3344, 2, 1, 32'h0, 0, 1);
    do_req("sb2", 1, 2'd0, 0, 32'h0D, 32'h0000_00AB, 3, 1, 32'h0, 0, 1);
    chk("sb2.mem3", mem[3], 32'h1122_AB44);

    do_req("lb3", 0, 2'd0, 0, 32'h0D, 32'h0, 2, 1, 32'hFFFF_FFAB, 0, 0);
    do_req("lbu3", 0, 2'd0, 1, 32'h0D, 32'h0, 2, 1, 32'h0000_00AB, 0, 0);
    do_req("lh3", 0, 2'd1, 0, 32'h0E, 32'h0, 2, 1, 32'h0000_1122, 0, 0);

    // Upper halfword store and extension of its sign bit
    do_req("sh4", 1, 2'd1, 0, 32'h3E, 32'h0000_8001, 3, 1, 32'h0, 0, 1);
    chk("sh4.mem15", mem[15], 32'h8001_0000);
    do_req("lh4", 0, 2'd1, 0, 32'h3E, 32'h0, 2, 1, 32'hFFFF_8001, 0, 0);
    do_req("lhu4", 0, 2'd1, 1, 32'h3E, 32'h0, 2, 1, 32'h0000_8001, 0, 0);
    do_req("lbu4", 0, 2'd0, 1, 32'h3F, 32'h0, 2, 1, 32'h0000_0080, 0, 0);

    // Misaligned requests with req_valid held across both
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h0E; req_wdata = 32'h0;
    @(posedge clk); #1;
    req_write = 1'b1; req_size = 2'd1; req_addr = 32'h0D; req_wdata = 32'h0000_BEEF;
    chk("mis_lw.valid", {31'h0, resp_valid}, 32'h1);
    chk("mis_lw.err", {31'h0, resp_err}, 32'h1);
    chk("mis_lw.ready", {31'h0, req_ready}, 32'h0);
    chk("mis_lw.we", {31'h0, mem_write_en}, 32'h0);
    @(posedge clk); #1;
    chk("mis_gap.valid", {31'h0, resp_valid}, 32'h0);
    chk("mis_gap.ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("mis_sh.valid", {31'h0, resp_valid}, 32'h1);
    chk("mis_sh.err", {31'h0, resp_err}, 32'h1);
    chk("mis_sh.we", {31'h0, mem_write_en}, 32'h0);
    @(posedge clk); #1;
    chk("mis.mem3", mem[3], 32'h1122_AB44);
    do_req("mis_sz3", 1, 2'd3, 0, 32'h0C, 32'hFFFF_FFFF, 1, 0, 32'h0, 1, 0);
    chk("mis_sz3.mem3", mem[3], 32'h1122_AB44);

    // Reset during WRITE must suppress the write
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h0C; req_wdata = 32'h0000_0055;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rstw.we_before", {31'h0, mem_write_en}, 32'h1);
    reset = 1'b1;
    #1;
    chk("rstw.we_masked", {31'h0, mem_write_en}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rstw.ready", {31'h0, req_ready}, 32'h1);
    chk("rstw.resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rstw.mem3", mem[3], 32'h1122_AB44);
    @(posedge clk); #1;
    chk("rstw.no_resp", {31'h0, resp_valid}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
